// File: rtl/color_palette_lut.sv
// color_palette_lut: self-filling palette RAM with one read port, one write port and optional output register.
module color_palette_lut #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24,
  parameter bit OUTPUT_REG = 0,
  parameter bit FILL_MODE = 0,
  parameter logic [47:0] FILL_VALUE = 48'hFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reinit,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_done
);
  typedef enum logic {FILL, RUN} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] fill_word;
  logic rd_go;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = (state == FILL) ? ((!reinit && cnt == LAST) ? RUN : FILL) : (reinit ? FILL : RUN);
    cnt_nx = (state == FILL && !reinit && cnt != LAST) ? cnt + 1'b1 : '0;
  end
  assign init_done = state == RUN;
  assign rd_go = rd_en && state == RUN;
  assign fill_word = FILL_MODE ? DATA_WIDTH'(cnt) : DATA_WIDTH'(FILL_VALUE);
  // No reset on the array: the fill sequence alone defines its contents.
  always_ff @(posedge clk)
    if (state == FILL) mem[cnt] <= fill_word;
    else if (wr_en) mem[wr_addr] <= wr_data;
  generate
    if (OUTPUT_REG) begin : g_reg
      logic [DATA_WIDTH-1:0] d1;
      logic v1;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          d1 <= '0;
          v1 <= 1'b0;
          rd_data <= '0;
          rd_valid <= 1'b0;
        end else begin
          v1 <= rd_go;
          if (rd_go) d1 <= mem[rd_addr];
          rd_valid <= v1;
          if (v1) rd_data <= d1;
        end
    end else begin : g_comb
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          rd_data <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_go;
          if (rd_go) rd_data <= mem[rd_addr];
        end
    end
  endgenerate
endmodule

// File: tb/tb_color_palette_lut.sv
// tb_color_palette_lut: directed checks plus a per-cycle reference model for two palette configurations.
module tb_color_palette_lut;
  logic clk = 0, rst = 1, reinit = 0, wr_en = 0, rd_en = 0;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [23:0] wr_data = 0;
  logic [23:0] rd0, rd1;
  logic rv0, rv1, id0, id1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  color_palette_lut dut0 (.clk(clk), .rst(rst), .reinit(reinit), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(rv0), .init_done(id0));
  color_palette_lut #(.FILL_MODE(1), .OUTPUT_REG(1)) dut1 (.clk(clk), .rst(rst), .reinit(reinit),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd1), .rd_valid(rv1), .init_done(id1));
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: fill_left counts remaining fill writes (0 = palette usable).
  int fl[2] = '{16, 16};
  logic [23:0] mm[2][16];
  logic xv[2] = '{0, 0}, pv[2] = '{0, 0}, iss;
  logic [23:0] xd[2] = '{0, 0}, pd[2] = '{0, 0}, rdat;
  initial forever begin
    @(posedge clk or posedge rst);
    for (int i = 0; i < 2; i++)
      if (rst) begin
        fl[i] = 16; xv[i] = 0; xd[i] = 0; pv[i] = 0;
      end else begin
        iss = 0; rdat = 0;
        if (fl[i] > 0) begin
          mm[i][16-fl[i]] = (i == 1) ? 24'(16 - fl[i]) : 24'hFFFFFF;
          fl[i] = reinit ? 16 : fl[i] - 1;
        end else begin
          iss = rd_en;
          rdat = mm[i][rd_addr];
          if (wr_en) mm[i][wr_addr] = wr_data;
          if (reinit) fl[i] = 16;
        end
        if (i == 1) begin
          xv[i] = pv[i];
          if (pv[i]) xd[i] = pd[i];
          pv[i] = iss; pd[i] = rdat;
        end else begin
          xv[i] = iss;
          if (iss) xd[i] = rdat;
        end
      end
  end
  initial forever begin
    @(posedge clk);
    #1;
    chk("m_valid0", rv0, xv[0]); chk("m_data0", rd0, xd[0]); chk("m_init0", id0, fl[0] == 0);
    chk("m_valid1", rv1, xv[1]); chk("m_data1", rd1, xd[1]); chk("m_init1", id1, fl[1] == 0);
  end
  task automatic tick(); @(negedge clk); endtask
  task automatic wait_init(input string nm);
    int n = 0;
    while (!id0 && n < 40) begin tick(); n++; end
    chk(nm, n, 16);
    chk({nm, "_dut1"}, id1, 1);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_data", rd0, 0); chk("rst_valid", rv0, 0); chk("rst_init", id0, 0);
    rst = 0;
    wait_init("fill_cycles");
    rd_en = 1;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      chk("stream0_valid", rv0, 1); chk("stream0_data", rd0, 24'hFFFFFF);
      if (a > 0) begin chk("stream1_valid", rv1, 1); chk("stream1_data", rd1, 24'(a - 1)); end
    end
    rd_en = 0;
    tick();
    chk("stream1_last", rd1, 24'h00000F);
    tick();
    rd_en = 1; rd_addr = 9;
    tick();
    rd_en = 0;
    chk("rd9_lat1", rv1, 0);
    tick();
    chk("rd9_valid", rv1, 1); chk("rd9_data", rd1, 24'h000009);
    wr_en = 1; wr_addr = 3; wr_data = 24'h123456; rd_en = 1; rd_addr = 3;
    tick();
    wr_en = 0;
    chk("rf_old", rd0, 24'hFFFFFF);
    tick();
    chk("rf_new", rd0, 24'h123456);
    wr_en = 1; wr_addr = 7; wr_data = 24'h0A0B0C; rd_addr = 4;
    tick();
    wr_en = 0; rd_addr = 7;
    chk("diff_rd", rd0, 24'hFFFFFF);
    tick();
    rd_en = 0;
    chk("diff_wr", rd0, 24'h0A0B0C);
    repeat (2) tick();
    chk("hold_valid", rv0, 0); chk("hold_data", rd0, 24'h0A0B0C);
    wr_en = 1; wr_addr = 5; wr_data = 24'hABCDEF;
    tick();
    wr_en = 0; reinit = 1; rd_en = 1; rd_addr = 5;
    tick();
    reinit = 0;
    chk("inflight0", rd0, 24'hABCDEF); chk("reinit_drop", id0, 0);
    rd_addr = 2; wr_en = 1; wr_addr = 2; wr_data = 24'h555555;
    begin
      int n = 0;
      while (!id0 && n < 40) begin
        tick(); n++;
        chk("fill_rv0", rv0, 0);
        if (n == 1) chk("inflight1", rd1, 24'hABCDEF);
        else chk("fill_rv1", rv1, 0);
      end
      chk("reinit_cycles", n, 16);
    end
    rd_en = 0; wr_en = 0;
    tick();
    rd_en = 1; rd_addr = 2;
    tick();
    rd_addr = 5;
    chk("ignored_wr", rd0, 24'hFFFFFF);
    tick();
    rd_en = 0;
    chk("refilled5", rd0, 24'hFFFFFF);
    repeat (2) tick();
    chk("refilled5_m1", rd1, 24'h000005);
    reinit = 1; rd_en = 1; rd_addr = 1;
    tick();
    reinit = 0; rd_en = 0;
    repeat (7) tick();
    #2 rst = 1;
    #1;
    chk("mid_rst_d0", rd0, 0); chk("mid_rst_d1", rd1, 0); chk("mid_rst_init", id0, 0);
    repeat (2) tick();
    rst = 0;
    wait_init("rst_refill");
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
